tile_dispatcher: RTL
====================

// Module: tile_dispatcher
// PURPOSE
//  Top-level tile scheduler for blocked matrix multiply C = A*B, with an mu x mu grid of k x k tiles.
//  Walks all (row,col) tile indices in row-major order and hands each one to an idle processor over the
//  index handshake (index_ready/index_ack). Tracks per-processor busy state through result_ready.
//  Raises done once all mu*mu tiles have completed. Sits directly upstream of the processor instances.
// PARAMETERS
//  NUM_PROC     2   number of processor instances served (1..8)
//  INDEX_WIDTH  8   width of row/col index and mu; matches the processors' index_width
//  CNT_WIDTH    2*INDEX_WIDTH   tile counter width (holds mu*mu)
// PORTS
//  in_clk           in   1            clock, all state updates on posedge
//  in_reset         in   1            asynchronous, active-low reset
//  in_start         in   1            1-cycle pulse: begin a multiply using in_mu
//  in_mu            in   INDEX_WIDTH  tiles per matrix dimension; sampled on in_start
//  in_index_ack     in   NUM_PROC     per-processor ack of the offered indices (level)
//  in_result_ready  in   NUM_PROC     per-processor tile-complete flag (level, may stay high >1 cycle)
//  out_row_index    out  INDEX_WIDTH  shared row index bus (i of C_ij)
//  out_col_index    out  INDEX_WIDTH  shared column index bus (j of C_ij)
//  out_mu           out  INDEX_WIDTH  latched mu, broadcast to all processors
//  out_index_ready  out  NUM_PROC     one-hot: indices valid for this processor
//  out_busy         out  1            high from start accept until done
//  out_done         out  1            high when all tiles are complete; held until next accepted start
//  out_tiles_done   out  CNT_WIDTH    count of completed tiles
// BEHAVIOUR
//  Reset: every output is 0; FSM=IDLE; busy mask, issue/complete counters, and edge registers are 0.
//  FSM states:
//   IDLE  : on in_start, latch mu, clear counters, set out_busy=1 and out_done=0. If mu==0 go to FIN,
//           else go to PICK.
//   PICK  : if an idle processor exists, pick the lowest-numbered one p. Drive row=issued/mu and
//           col=issued%mu (tracked as row/col counters, no divider). Set out_index_ready[p]=1 and go
//           to OFFER. If no processor is idle, stay in PICK.
//   OFFER : hold indices and out_index_ready[p] until in_index_ack[p]=1. On that edge: set busy[p],
//           issued++, advance col (wrap to 0 and row++ at mu-1), deassert index_ready next cycle.
//           Go to PICK if issued<mu*mu, else to DRAIN.
//   DRAIN : wait until completed==mu*mu, then go to FIN.
//   FIN   : set out_done=1 and out_busy=0, go to IDLE. out_done stays 1 in IDLE until the next start.
//  Latency: start -> first out_index_ready is 2 cycles (IDLE->PICK->OFFER registered).
//  Completion: detect the rising edge of in_result_ready[q] only when busy[q]=1. Clear busy[q] and
//   add the popcount of all simultaneous edges to the completed count. Edges on non-busy processors
//   are ignored. Completion is processed in every state, including PICK and OFFER.
//  Simultaneous events: completion of q and selection of a processor in the same cycle. PICK uses
//   the busy mask registered before this cycle's clears, so a freed processor is usable from the
//   next cycle.
//  in_start is ignored while out_busy=1. in_index_ack on non-offered processors is ignored.
//  Width rule: mu*mu is computed once at start into CNT_WIDTH; the counters never wrap.
//  Asynchronous reset mid-operation aborts immediately; outputs return to reset values and the
//   processors rely on their own reset.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE,PICK,OFFER,DRAIN,FIN) and the default widths.
//  Sub-module: prio_pick #(N) - combinational lowest-index-idle encoder returning a one-hot
//   grant plus a valid bit. All other logic is inline.
// TESTING
//  1 mu=2, NUM_PROC=2, processors ack after 1 cycle and finish after 10 cycles -> tiles
//    (0,0)->P0, (0,1)->P1, (1,0),(1,1) issued as each frees; out_tiles_done=4, out_done=1,
//    out_busy=0.
//  2 mu=0 start -> out_done=1 within 3 cycles; no out_index_ready ever asserted.
//  3 Hold in_result_ready[0] high for 5 cycles -> counted exactly once; spurious result_ready[1]
//    while P1 idle -> count unchanged.
//  4 P0 and P1 complete in the same cycle with mu=3 -> completed increments by 2; both reissued;
//    final count 9.
//  5 Delay in_index_ack[0] by 20 cycles -> indices and index_ready stable throughout; tile not
//    double-issued.
//  6 Assert in_reset low mid-DRAIN, then release and start mu=1 -> all outputs 0 during reset;
//    new run finishes with out_tiles_done=1.

Source files
------------

// File: rtl/tile_dispatcher_pkg.sv
// Shared FSM encodings, default widths and a small popcount helper for the tile dispatcher.
package tile_dispatcher_pkg;

  localparam int DEF_NUM_PROC    = 2;
  localparam int DEF_INDEX_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_OFFER = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Up to eight processors, so an 8-bit popcount covers every legal NUM_PROC.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tile_dispatcher_prio_pick.sv
// Lowest-index request encoder: one-hot grant plus valid, purely combinational.
module prio_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         vld
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));
  assign vld   = |req;

endmodule

// File: rtl/tile_dispatcher.sv
// Walks an mu x mu tile grid row-major, offering each (row,col) to the lowest idle processor.
// Start to first index_ready is 2 cycles; an offer is held until the chosen processor acks.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_PROC    = DEF_NUM_PROC,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int CNT_WIDTH   = 2 * INDEX_WIDTH
) (
  input  logic                   in_clk,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic [INDEX_WIDTH-1:0] in_mu,
  input  logic [NUM_PROC-1:0]    in_index_ack,
  input  logic [NUM_PROC-1:0]    in_result_ready,
  output logic [INDEX_WIDTH-1:0] out_row_index,
  output logic [INDEX_WIDTH-1:0] out_col_index,
  output logic [INDEX_WIDTH-1:0] out_mu,
  output logic [NUM_PROC-1:0]    out_index_ready,
  output logic                   out_busy,
  output logic                   out_done,
  output logic [CNT_WIDTH-1:0]   out_tiles_done
);

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] mu_q, row_q, col_q;
  logic [CNT_WIDTH-1:0]   total_q, issued_q, completed_q;
  logic [NUM_PROC-1:0]    busy_q, rr_q, offer_q;
  logic                   busy_out_q, done_q;

  logic [NUM_PROC-1:0]    grant;
  logic                   grant_vld;
  logic [NUM_PROC-1:0]    comp_edge;
  logic [7:0]             edge_pad;
  logic                   ack_hit;
  logic                   start_acc, pick_fire, ack_fire, fin;

  // Selection sees the busy mask from before this cycle's completions.
  prio_pick #(.N(NUM_PROC)) u_pick (
    .req   (~busy_q),
    .grant (grant),
    .vld   (grant_vld)
  );

  assign comp_edge = in_result_ready & ~rr_q & busy_q;
  assign ack_hit   = |(in_index_ack & offer_q);

  always_comb begin
    edge_pad                = '0;
    edge_pad[NUM_PROC-1:0]  = comp_edge;
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    pick_fire = 1'b0;
    ack_fire  = 1'b0;
    fin       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          start_acc = 1'b1;
          state_d   = (in_mu == '0) ? ST_FIN : ST_PICK;
        end
      end
      ST_PICK: begin
        if (grant_vld) begin
          pick_fire = 1'b1;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (ack_hit) begin
          ack_fire = 1'b1;
          state_d  = ((issued_q + CNT_WIDTH'(1)) < total_q) ? ST_PICK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (completed_q == total_q) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        fin     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      mu_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      busy_q      <= '0;
      rr_q        <= '0;
      offer_q     <= '0;
      busy_out_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rr_q   <= in_result_ready;
      busy_q <= (busy_q & ~comp_edge) | (ack_fire ? offer_q : '0);

      if (start_acc) begin
        mu_q        <= in_mu;
        total_q     <= CNT_WIDTH'(in_mu) * CNT_WIDTH'(in_mu);
        issued_q    <= '0;
        row_q       <= '0;
        col_q       <= '0;
        completed_q <= '0;
        busy_out_q  <= 1'b1;
        done_q      <= 1'b0;
      end else begin
        completed_q <= completed_q + CNT_WIDTH'(popcount8(edge_pad));
      end

      if (pick_fire) begin
        offer_q <= grant;
      end

      if (ack_fire) begin
        offer_q  <= '0;
        issued_q <= issued_q + CNT_WIDTH'(1);
        if (col_q == mu_q - INDEX_WIDTH'(1)) begin
          col_q <= '0;
          row_q <= row_q + INDEX_WIDTH'(1);
        end else begin
          col_q <= col_q + INDEX_WIDTH'(1);
        end
      end

      if (fin) begin
        done_q     <= 1'b1;
        busy_out_q <= 1'b0;
      end
    end
  end

  assign out_row_index   = row_q;
  assign out_col_index   = col_q;
  assign out_mu          = mu_q;
  assign out_index_ready = offer_q;
  assign out_busy        = busy_out_q;
  assign out_done        = done_q;
  assign out_tiles_done  = completed_q;

endmodule
